// File: rtl/spi_readback_pkg.sv
// Shared types, frame layout constants and the CRC-8 step for the SPI readback path.
// Frame length grows by one CRC byte when SPI_READBACK_CRC_EN is defined.
package spi_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int FRAME_LEN_BASE = 5;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    localparam int IDX_HDR  = 0;
    localparam int IDX_DIN  = 1;
    localparam int IDX_WIN  = 2;
    localparam int IDX_BIAS = 3;
    localparam int IDX_RES  = 4;
    localparam int IDX_CRC  = 5;

`ifdef SPI_READBACK_CRC_EN
    localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin with rise/fall pulse detection.
// Pulses are combinational from the last sync stage, so the consumer acts SYNC_STAGES+1 clk after the pin.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_readback_tx.sv
// SPI mode-0 slave transmitter returning {header, din, win, bias, result} to the host.
// Define SPI_READBACK_CRC_EN to append a CRC-8 byte over the first five bytes.
module spi_readback_tx
    import spi_readback_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] HDR_NIBBLE  = 4'hA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] win,
    input  logic [7:0] bias,
    input  logic [7:0] result,
    input  logic       result_valid,
    input  logic       sclk,
    input  logic       cs_n,
    output logic       miso,
    output logic       miso_oe,
    output logic       byte_sent,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst(rst), .d(cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    state_t                    state_q, state_d;
    logic [7:0]                shreg_q, shreg_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [2:0]                byte_idx_q, byte_idx_d;
    logic [2:0]                next_idx;
    logic [FRAME_LEN-1:0][7:0] frame_q, frame_d, snap;
    logic                      rise_seen_q, rise_seen_d;
    logic                      miso_d, miso_oe_d, busy_d, byte_sent_d, frame_done_d;
`ifdef SPI_READBACK_CRC_EN
    logic [7:0]                crc_acc;
`endif

    always_comb begin
        snap           = '0;
        snap[IDX_HDR]  = {HDR_NIBBLE, 3'b000, result_valid};
        snap[IDX_DIN]  = din;
        snap[IDX_WIN]  = win;
        snap[IDX_BIAS] = bias;
        snap[IDX_RES]  = result;
`ifdef SPI_READBACK_CRC_EN
        crc_acc = 8'h00;
        for (int i = 0; i < FRAME_LEN_BASE; i++) begin
            crc_acc = crc8_step(crc_acc, snap[i]);
        end
        snap[IDX_CRC] = crc_acc;
`endif
    end

    assign next_idx = byte_idx_q + 3'd1;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        frame_d      = frame_q;
        rise_seen_d  = rise_seen_q;
        miso_d       = miso;
        miso_oe_d    = miso_oe;
        busy_d       = busy;
        byte_sent_d  = 1'b0;
        frame_done_d = 1'b0;

        if (cs_rise) begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    frame_d     = snap;
                    shreg_d     = snap[IDX_HDR];
                    bit_cnt_d   = 3'd7;
                    byte_idx_d  = 3'd0;
                    rise_seen_d = 1'b0;
                    miso_d      = snap[IDX_HDR][7];
                    miso_oe_d   = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise) rise_seen_d = 1'b1;
                    // A falling edge only advances data once the host has sampled the current bit.
                    if (sclk_fall && rise_seen_q) begin
                        rise_seen_d = 1'b0;
                        if (bit_cnt_q != 3'd0) begin
                            shreg_d   = shreg_q << 1;
                            miso_d    = shreg_q[6];
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end else if (byte_idx_q == LAST_IDX) begin
                            byte_sent_d  = 1'b1;
                            frame_done_d = 1'b1;
                            miso_d       = 1'b0;
                            state_d      = ST_DONE;
                        end else begin
                            byte_sent_d = 1'b1;
                            byte_idx_d  = next_idx;
                            shreg_d     = frame_q[next_idx];
                            miso_d      = frame_q[next_idx][7];
                            bit_cnt_d   = 3'd7;
                        end
                    end
                end
                ST_DONE: begin
                    miso_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: the frame snapshot is reset with everything else; it is only 5-6 bytes of flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            byte_idx_q  <= '0;
            frame_q     <= '0;
            rise_seen_q <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            byte_sent   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            frame_q     <= frame_d;
            rise_seen_q <= rise_seen_d;
            miso        <= miso_d;
            miso_oe     <= miso_oe_d;
            busy        <= busy_d;
            byte_sent   <= byte_sent_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule

// File: doc/spi_readback_tx.md
Name: spi_readback_tx

Overview:
- SPI slave transmit path: the MISO-side counterpart of spi_controller, which receives bytes and loads din/win/bias.
- Lets the off-chip host read back the loaded configuration (din, win, bias) and the accelerator result over the same SPI port.
- SPI mode 0, MSB first. The block oversamples sclk and cs_n on the system clock, so the SPI pins need no separate clock domain.
- Sits beside the SPI receiver and spi_controller. It drives miso and miso_oe to the pad.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each synchronizer for sclk and cs_n (minimum 2).
- HDR_NIBBLE, 4'hA, upper nibble of the header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low; all flops are cleared while rst=0.
- din  in  8  currently loaded data register.
- win  in  8  currently loaded weight register.
- bias  in  8  currently loaded bias register.
- result  in  8  accelerator output byte.
- result_valid  in  1  result is valid.
- sclk  in  1  SPI clock from host (asynchronous).
- cs_n  in  1  SPI chip select from host, active-low (asynchronous).
- miso  out  1  serial data to host.
- miso_oe  out  1  pad output enable; 1 while the frame is active.
- byte_sent  out  1  one-clk pulse when a byte has been fully shifted out.
- frame_done  out  1  one-clk pulse when the last frame byte has been shifted out.
- busy  out  1  high from frame start until cs_n deasserts.

Behaviour:
Reset values:
- miso=0, miso_oe=0, byte_sent=0, frame_done=0, busy=0.
- State IDLE; shift register, bit counter and byte index all 0.

Synchronization and edges:
- sclk and cs_n each pass through SYNC_STAGES flops. Edges are detected on the synchronized values.
- Latency from pin to detected edge: SYNC_STAGES+1 clk.
- sclk is legal up to clk/8. The first sclk rising edge must come at least 4 clk after cs_n falls.

Frame contents (snapshotted at frame start, held stable for the whole frame):
- Byte 0: header = {HDR_NIBBLE, 3'b000, result_valid}.
- Byte 1: din. Byte 2: win. Byte 3: bias. Byte 4: result.
- FRAME_LEN = 5.

States:
- IDLE: on cs_n synced falling → LOAD.
- LOAD (1 clk):
  - snapshot the frame; shift register = byte 0; bit_cnt=7; byte_idx=0.
  - miso_oe=1, busy=1; miso = MSB of byte 0 from the next clk.
  - → SHIFT.
- SHIFT:
  - Data changes only on sclk synced falling edge; the host samples on the rising edge.
  - On each falling edge: shift left and present the next bit; bit_cnt decrements.
  - When the falling edge arrives with bit_cnt=0 and the byte is not the last:
    - byte_sent pulses; byte_idx++.
    - The next byte loads and its MSB appears on miso in the same update.
  - When the falling edge arrives with bit_cnt=0 and the byte is the last (byte_idx=FRAME_LEN-1):
    - byte_sent and frame_done both pulse.
    - miso=0; → DONE.
- DONE:
  - miso=0, miso_oe=1, busy=1.
  - Further sclk edges are ignored (host over-read returns 0x00).

Boundary conditions:
- cs_n synced rising in any state → IDLE next clk; miso=0, miso_oe=0, busy=0.
  - An aborted frame produces no frame_done.
  - The current partial byte produces no byte_sent.
- sclk edges while in IDLE are ignored.
- cs_n falling again after IDLE starts a fresh snapshot.
- Input changes during a frame do not affect that frame.
- rst asserted mid-frame: immediate return to reset values.

Optional Feature:
- Macro: SPI_READBACK_CRC_EN.
- When defined:
  - FRAME_LEN=6. Byte 5 is CRC-8 (poly 0x07, init 0x00, MSB first, no reflection, no final XOR) over bytes 0–4.
  - The CRC is computed during LOAD from the snapshot and is ready before byte 5 is shifted.
  - frame_done follows byte 5.
- When undefined: FRAME_LEN=5, and no CRC logic is present.

Decomposition:
- Package spi_readback_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - FRAME_LEN_BASE=5;
  - CRC8_POLY=8'h07;
  - byte-index constants (HDR, DIN, WIN, BIAS, RES, CRC);
  - a function computing the CRC-8 step over one byte.
- One sub-module: spi_sync_edge (SYNC_STAGES synchronizer plus rise/fall pulse outputs), instantiated once for sclk and once for cs_n.

Test Plan:
- Reset check: rst=0 with random inputs → miso=0, miso_oe=0, busy=0. Release rst with cs_n=1 → outputs stay idle.
- Basic readback: din=127, win=12, bias=1, result=16, result_valid=1; 40 sclk cycles at clk/8 → host captures A1 7F 0C 01 10.
  - byte_sent pulses 5 times; frame_done pulses exactly once.
- Snapshot hold: same frame, but change din to 0x55 after byte 1 starts → host still reads 0x7F; result_valid=0 at cs_n fall gives header 0xA0.
- Abort: raise cs_n after 12 sclk cycles → miso_oe=0 within SYNC_STAGES+2 clk.
  - No frame_done; byte_sent pulsed once.
  - A new frame then reads A1 from byte 0.
- Over-read: 48 sclk cycles → last 8 bits read 0x00; frame_done pulses only once.
- With SPI_READBACK_CRC_EN: basic-readback inputs, 48 sclk cycles → host reads A1 7F 0C 01 10 EE; frame_done after the 6th byte.
